// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read-port arbiter.
// Fallback widths for builds that do not pass the system-wide defines.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam int LEN_WIDTH = 4;
    localparam int ID_WIDTH  = 4;

    localparam int REQ_ICACHE   = 0;
    localparam int REQ_DCACHE   = 1;
    localparam int REQ_PREFETCH = 2;

endpackage

// File: rtl/mem_read_arbiter_rr_picker.sv
// Round-robin picker: first requesting index at or after rr_ptr, wrapping
// modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       rr_ptr,
    output logic [1:0]       grant,
    output logic             any_req
);
    import mem_arb_pkg::*;

    // Walk offsets from farthest to nearest so the nearest match is written last and wins.
    always_comb begin
        grant   = 2'd0;
        any_req = |req;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && (i == ((int'(rr_ptr) + off) % N_REQ))) begin
                    grant = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between N_REQ cache-refill requesters, one burst
// at a time, round-robin; the owner's address/data channels pass through combinationally.
module mem_read_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int LEN_WIDTH  = mem_arb_pkg::LEN_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_WIDTH-1:0]               req_araddr [N_REQ],
    input  logic [LEN_WIDTH-1:0]                req_arlen  [N_REQ],
    input  logic [N_REQ-1:0]                    req_arvalid,
    output logic [N_REQ-1:0]                    req_arready,
    output logic [DATA_WIDTH-1:0]               req_rdata,
    output logic [N_REQ-1:0]                    req_rvalid,
    input  logic [N_REQ-1:0]                    req_rready,
    output logic [ADDR_WIDTH-1:0]               mem_araddr,
    output logic [LEN_WIDTH-1:0]                mem_arlen,
    output logic [mem_arb_pkg::ID_WIDTH-1:0]    mem_arid,
    output logic                                mem_arvalid,
    input  logic                                mem_arready,
    input  logic [DATA_WIDTH-1:0]               mem_rdata,
    input  logic                                mem_rvalid,
    output logic                                mem_rready,
    output logic [1:0]                          o_owner,
    output logic                                o_busy
);
    import mem_arb_pkg::*;

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [1:0]             owner;
    logic [1:0]             rr_ptr;
    logic [1:0]             grant;
    logic                   any_req;
    logic [LEN_WIDTH:0]     beats_left;

    logic [ADDR_WIDTH-1:0]  own_araddr;
    logic [LEN_WIDTH-1:0]   own_arlen;
    logic                   own_rready;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   last_beat;

    function automatic logic [1:0] ptr_after(input logic [1:0] idx);
        if (int'(idx) >= N_REQ - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

    rr_picker #(
        .N_REQ   (N_REQ)
    ) u_picker (
        .req     (req_arvalid),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    // Owner-indexed view of the requester inputs.
    always_comb begin
        own_araddr = '0;
        own_arlen  = '0;
        own_rready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == 2'(i)) begin
                own_araddr = req_araddr[i];
                own_arlen  = req_arlen[i];
                own_rready = req_rready[i];
            end
        end
    end

    assign ar_hs     = (state == ARB_ADDR) && mem_arready;
    assign r_hs      = (state == ARB_DATA) && mem_rvalid && own_rready;
    assign last_beat = r_hs && (beats_left == (LEN_WIDTH + 1)'(1));

    // Next state and handshake steering; beats outside DATA are dropped.
    always_comb begin
        state_nxt   = state;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        req_arready = '0;
        req_rvalid  = '0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_nxt = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                mem_arvalid = 1'b1;
                for (int i = 0; i < N_REQ; i++) begin
                    req_arready[i] = (owner == 2'(i)) && mem_arready;
                end
                if (mem_arready) begin
                    state_nxt = (own_arlen == '0) ? ARB_IDLE : ARB_DATA;
                end
            end
            ARB_DATA: begin
                mem_rready = own_rready;
                for (int i = 0; i < N_REQ; i++) begin
                    req_rvalid[i] = (owner == 2'(i)) && mem_rvalid;
                end
                if (last_beat) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= 2'd0;
            rr_ptr     <= 2'd0;
            beats_left <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ARB_IDLE) && any_req) begin
                owner <= grant;
            end
            if (ar_hs) begin
                beats_left <= {1'b0, own_arlen};
                if (own_arlen == '0) begin
                    rr_ptr <= ptr_after(owner);
                end
            end
            if (r_hs) begin
                beats_left <= beats_left - (LEN_WIDTH + 1)'(1);
                if (last_beat) begin
                    rr_ptr <= ptr_after(owner);
                end
            end
        end
    end

    assign mem_araddr = own_araddr;
    assign mem_arlen  = own_arlen;
    assign mem_arid   = ID_WIDTH'(owner);
    assign req_rdata  = mem_rdata;
    assign o_owner    = owner;
    assign o_busy     = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: a memory model serves bursts while a
// negedge monitor checks delivered beats against a scoreboard queue.
module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     req_araddr [N];
    logic [LW-1:0]     req_arlen  [N];
    logic [N-1:0]      req_arvalid;
    logic [N-1:0]      req_arready;
    logic [DW-1:0]     req_rdata;
    logic [N-1:0]      req_rvalid;
    logic [N-1:0]      req_rready;
    logic [AW-1:0]     mem_araddr;
    logic [LW-1:0]     mem_arlen;
    logic [ID_WIDTH-1:0] mem_arid;
    logic              mem_arvalid;
    logic              mem_arready;
    logic [DW-1:0]     mem_rdata;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [1:0]        o_owner;
    logic              o_busy;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [33:0]       sb_q [$];
    logic [33:0]       sb_exp;
    logic [1:0]        mon_who;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_arvalid (req_arvalid),
        .req_arready (req_arready),
        .req_rdata   (req_rdata),
        .req_rvalid  (req_rvalid),
        .req_rready  (req_rready),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arid    (mem_arid),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .o_owner     (o_owner),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_arready"}, req_arready, 0);
        chk({tag, "_rvalid"}, req_rvalid, 0);
        chk({tag, "_arvalid"}, mem_arvalid, 0);
        chk({tag, "_rready"}, mem_rready, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_owner"}, o_owner, 0);
    endtask

    // Delivered beats: handshake is stable from posedge+1 until the next posedge.
    always @(negedge clk) begin
        if (!rst && ((req_rvalid & req_rready) != '0)) begin
            mon_who = 2'd0;
            for (int i = 0; i < N; i++) begin
                if (req_rvalid[i] && req_rready[i]) mon_who = 2'(i);
            end
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_beat", 1, 0);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_beat", {mon_who, req_rdata}, sb_exp);
            end
        end
    end

    // Acts as memory for one burst expected from requester idx.
    task automatic serve(input int idx, input logic [AW-1:0] addr, input int len,
                         input int ar_delay, input int stall, input logic keep,
                         input logic [DW-1:0] base, input int abort_after);
        int waited = 0;
        int st = stall;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!mem_arvalid && waited < 20);
        chk("ar_latency", waited, 1);
        if (!mem_arvalid) return;
        chk("arid", mem_arid, idx);
        chk("araddr", mem_araddr, addr);
        chk("arlen", mem_arlen, len);
        chk("owner", o_owner, idx);
        chk("busy_addr", o_busy, 1);
        for (int d = 0; d < ar_delay; d++) begin
            mem_rvalid = 1'b1;
            req_rready = '1;
            #1;
            chk("arready_hold", req_arready, 0);
            chk("rvalid_in_addr", req_rvalid, 0);
            chk("rready_in_addr", mem_rready, 0);
            @(posedge clk); #1;
            chk("arvalid_held", mem_arvalid, 1);
        end
        mem_rvalid  = 1'b0;
        req_rready  = '0;
        mem_arready = 1'b1;
        #1;
        chk("arready_owner", req_arready, 1 << idx);
        @(posedge clk); #1;
        mem_arready = 1'b0;
        if (!keep) req_arvalid[idx] = 1'b0;
        for (int b = 0; b < len; b++) begin
            if (abort_after > 0 && b == abort_after) begin
                rst         = 1'b1;
                mem_rvalid  = 1'b0;
                req_rready  = '0;
                req_arvalid = '0;
                @(posedge clk); #1;
                rst = 1'b0;
                #1;
                chk_idle("rst_mid");
                return;
            end
            sb_q.push_back({2'(idx), base + DW'(b)});
            mem_rvalid = 1'b1;
            mem_rdata  = base + DW'(b);
            forever begin
                req_rready[idx] = (st == 0);
                #1;
                chk("rvalid_owner", req_rvalid, 1 << idx);
                chk("rready_follow", mem_rready, req_rready[idx]);
                chk("busy_data", o_busy, 1);
                @(posedge clk); #1;
                if (req_rready[idx]) break;
                st--;
            end
        end
        mem_rvalid = 1'b0;
        req_rready = '0;
        #1;
        chk("idle_after_burst", o_busy, 0);
        chk("no_arvalid_in_idle", mem_arvalid, 0);
        chk("rvalid_after_burst", req_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_arvalid = '0;
        req_rready  = '0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        for (int i = 0; i < N; i++) begin
            req_araddr[i] = '0;
            req_arlen[i]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;

        // Beats in IDLE are dropped.
        mem_rvalid = 1'b1;
        req_rready = '1;
        #1;
        chk("rvalid_in_idle", req_rvalid, 0);
        chk("rready_in_idle", mem_rready, 0);
        mem_rvalid = 1'b0;
        req_rready = '0;

        // Single burst from i_cache.
        req_araddr[REQ_ICACHE] = 26'h100;
        req_arlen[REQ_ICACHE]  = 4'd4;
        req_arvalid[REQ_ICACHE] = 1'b1;
        serve(REQ_ICACHE, 26'h100, 4, 0, 0, 1'b0, 32'hA0, 0);

        // Contention from reset: i_cache first, d_cache right after.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_araddr[0] = 26'h200; req_arlen[0] = 4'd2;
        req_araddr[1] = 26'h300; req_arlen[1] = 4'd2;
        req_arvalid = 2'b11;
        serve(0, 26'h200, 2, 0, 0, 1'b0, 32'hB0, 0);
        serve(1, 26'h300, 2, 0, 0, 1'b0, 32'hC0, 0);

        // Fairness with both requesting continuously.
        req_arvalid = 2'b11;
        serve(0, 26'h200, 2, 0, 0, 1'b1, 32'hD0, 0);
        serve(1, 26'h300, 2, 0, 0, 1'b1, 32'hD8, 0);
        serve(0, 26'h200, 2, 0, 0, 1'b1, 32'hE0, 0);
        serve(1, 26'h300, 2, 0, 0, 1'b1, 32'hE8, 0);
        req_arvalid = '0;

        // Zero length advances the pointer, so d_cache wins next.
        req_araddr[0] = 26'h400; req_arlen[0] = 4'd0;
        req_arvalid[0] = 1'b1;
        serve(0, 26'h400, 0, 0, 0, 1'b0, 32'h0, 0);
        req_arlen[0] = 4'd1;
        req_arlen[1] = 4'd1;
        req_arvalid  = 2'b11;
        serve(1, 26'h300, 1, 0, 0, 1'b0, 32'hF0, 0);
        serve(0, 26'h400, 1, 0, 0, 1'b0, 32'hF8, 0);

        // Backpressure on both channels.
        req_araddr[0] = 26'h500; req_arlen[0] = 4'd4;
        req_arvalid[0] = 1'b1;
        serve(0, 26'h500, 4, 3, 2, 1'b0, 32'h1000, 0);

        // Reset after the second of four beats, then a d_cache burst.
        req_araddr[0] = 26'h600; req_arlen[0] = 4'd4;
        req_arvalid[0] = 1'b1;
        serve(0, 26'h600, 4, 0, 0, 1'b0, 32'h2000, 2);
        req_araddr[1] = 26'h700; req_arlen[1] = 4'd2;
        req_arvalid[1] = 1'b1;
        serve(1, 26'h700, 2, 0, 0, 1'b0, 32'h3000, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
